// File: rtl/fp_div_serial.sv
// Multi-cycle IEEE-754-style divider: radix-2 restoring mantissa division, one
// quotient bit per cycle, round-to-nearest-even, full special-case handling.
module fp_div_serial #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int DATA_W = 1 + EXP_W + MAN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] res,
  output logic              overflow,
  output logic              underflow,
  output logic              invalid,
  output logic              div_by_zero,
  output logic [1:0]        dbg_state
);

  localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
  localparam int SIG_W = MAN_W + 1;
  localparam int Q_W   = MAN_W + 3;
  localparam int E_W   = EXP_W + 2;
  localparam int CNT_W = $clog2(MAN_W + 3);

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAN_W + 2);
  localparam logic [E_W-1:0]    EXP_MAX  = E_W'((1 << EXP_W) - 1);
  localparam logic [DATA_W-1:0] QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DIV   = 2'd1,
    S_ROUND = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] a_q, b_q;
  logic [SIG_W:0]    rem_q;
  logic [Q_W-1:0]    quo_q;

  // Handshake: start is taken only while busy=0 (including the done cycle);
  // busy stays high until the single-cycle done pulse, and res/flags hold
  // from that pulse until the next one.
  logic accept;
  assign accept = (state == S_IDLE) && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_DIV;
      S_DIV:   if (cnt == CNT_LAST) state_nx = S_ROUND;
      S_ROUND: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    dbg_state = state;
  end

  // Restoring step: the partial remainder always stays below twice the divisor.
  logic [SIG_W:0] div_mb, rem_diff, rem_shift;
  logic           q_bit;

  always_comb begin
    div_mb    = {2'b01, b_q[MAN_W-1:0]};
    q_bit     = (rem_q >= div_mb);
    rem_diff  = q_bit ? (rem_q - div_mb) : rem_q;
    rem_shift = {rem_diff[SIG_W-1:0], 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      rem_q <= '0;
      quo_q <= '0;
      cnt   <= '0;
    end else if (accept) begin
      a_q   <= op_a;
      b_q   <= op_b;
      rem_q <= {2'b01, op_a[MAN_W-1:0]};
      quo_q <= '0;
      cnt   <= '0;
    end else if (state == S_DIV) begin
      rem_q <= rem_shift;
      quo_q <= {quo_q[Q_W-2:0], q_bit};
      cnt   <= cnt + 1'b1;
    end
  end

  logic             a_sign, b_sign, r_sign;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_frac, b_frac;
  logic             a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;

  always_comb begin
    {a_sign, a_exp, a_frac} = a_q;
    {b_sign, b_exp, b_frac} = b_q;
    r_sign = a_sign ^ b_sign;
    a_zero = (a_exp == '0);
    a_inf  = (a_exp == '1) && (a_frac == '0);
    a_nan  = (a_exp == '1) && (a_frac != '0);
    b_zero = (b_exp == '0);
    b_inf  = (b_exp == '1) && (b_frac == '0);
    b_nan  = (b_exp == '1) && (b_frac != '0);
  end

  logic             norm, guard, sticky, inc;
  logic [SIG_W-1:0] sig;
  logic [SIG_W:0]   sig_rnd;
  logic [E_W-1:0]   exp_fin;
  logic [DATA_W-1:0] res_nx;
  logic             ovf_nx, unf_nx, inv_nx, dz_nx;

  always_comb begin
    // A quotient below 1.0 has its leading one one place lower.
    norm = ~quo_q[Q_W-1];
    if (norm) begin
      sig    = quo_q[Q_W-2:1];
      guard  = quo_q[0];
      sticky = |rem_q;
    end else begin
      sig    = quo_q[Q_W-1:2];
      guard  = quo_q[1];
      sticky = quo_q[0] | (|rem_q);
    end
    inc     = guard & (sticky | sig[0]);
    sig_rnd = {1'b0, sig} + {{SIG_W{1'b0}}, inc};
    exp_fin = {2'b00, a_exp} - {2'b00, b_exp} + E_W'(BIAS)
              - {{(E_W-1){1'b0}}, norm} + {{(E_W-1){1'b0}}, sig_rnd[SIG_W]};

    res_nx = {r_sign, exp_fin[EXP_W-1:0], sig_rnd[MAN_W-1:0]};
    ovf_nx = 1'b0;
    unf_nx = 1'b0;
    inv_nx = 1'b0;
    dz_nx  = 1'b0;

    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      res_nx = QNAN;
      inv_nx = 1'b1;
    end else if (b_zero) begin
      res_nx = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      dz_nx  = 1'b1;
    end else if (a_inf) begin
      res_nx = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (a_zero || b_inf) begin
      res_nx = {r_sign, {(DATA_W-1){1'b0}}};
    end else if ($signed(exp_fin) >= $signed(EXP_MAX)) begin
      res_nx = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf_nx = 1'b1;
    end else if ($signed(exp_fin) <= $signed({E_W{1'b0}})) begin
      res_nx = {r_sign, {(DATA_W-1){1'b0}}};
      unf_nx = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done        <= 1'b0;
      res         <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      invalid     <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (state == S_ROUND) begin
      done        <= 1'b1;
      res         <= res_nx;
      overflow    <= ovf_nx;
      underflow   <= unf_nx;
      invalid     <= inv_nx;
      div_by_zero <= dz_nx;
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fp_div_serial.sv
// Bench for fp_div_serial: directed vector table, timing/abort sequences and
// random operands scored against an arithmetic reference model.
module tb_fp_div_serial;

  localparam logic [31:0] ONE   = 32'h3F800000;
  localparam logic [31:0] THREE = 32'h40400000;

  logic        clk, rst;
  logic        start;
  logic [31:0] op_a, op_b, res;
  logic        busy, done, overflow, underflow, invalid, div_by_zero;
  logic [1:0]  dbg_state;

  logic        start64;
  logic [63:0] op_a64, op_b64, res64;
  logic        busy64, done64, ovf64, unf64, inv64, dz64;
  logic [1:0]  dbg_state64;

  int n_checks = 0;
  int n_errors = 0;
  logic [67:0] exp_q[$];

  fp_div_serial u_dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .res(res), .overflow(overflow),
    .underflow(underflow), .invalid(invalid), .div_by_zero(div_by_zero),
    .dbg_state(dbg_state)
  );

  fp_div_serial #(.EXP_W(11), .MAN_W(52)) u_dut64 (
    .clk(clk), .rst(rst), .start(start64), .op_a(op_a64), .op_b(op_b64),
    .busy(busy64), .done(done64), .res(res64), .overflow(ovf64),
    .underflow(unf64), .invalid(inv64), .div_by_zero(dz64),
    .dbg_state(dbg_state64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flags;   // {overflow, underflow, invalid, div_by_zero}
    string       name;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Reference: exact quotient scaled by 2^64, then round-to-nearest-even.
  function automatic logic [67:0] model(input int ew, input int mw,
                                        input logic [63:0] a, input logic [63:0] b);
    int emax, bias, ea, eb, e, lead, shift;
    logic [63:0] fmask, fa, fb, r64, qnan, inf_v, zero_v;
    logic sa, sb, s, az, ai, an, bz, bi, bn, guard, sticky;
    logic [127:0] ma, mb, num, q, rm, sig;
    emax  = (1 << ew) - 1;
    bias  = (1 << (ew - 1)) - 1;
    fmask = (64'd1 << mw) - 64'd1;
    sa = a[ew+mw];
    sb = b[ew+mw];
    s  = sa ^ sb;
    ea = int'((a >> mw) & 64'(emax));
    eb = int'((b >> mw) & 64'(emax));
    fa = a & fmask;
    fb = b & fmask;
    az = (ea == 0); ai = (ea == emax) && (fa == 0); an = (ea == emax) && (fa != 0);
    bz = (eb == 0); bi = (eb == emax) && (fb == 0); bn = (eb == emax) && (fb != 0);
    qnan   = (64'(emax) << mw) | (64'd1 << (mw - 1));
    inf_v  = (64'(s) << (ew + mw)) | (64'(emax) << mw);
    zero_v = 64'(s) << (ew + mw);
    if (an || bn || (az && bz) || (ai && bi)) return {4'b0010, qnan};
    if (bz) return {4'b0001, inf_v};
    if (ai) return {4'b0000, inf_v};
    if (az || bi) return {4'b0000, zero_v};
    ma  = {64'd0, (64'd1 << mw) | fa};
    mb  = {64'd0, (64'd1 << mw) | fb};
    num = ma << 64;
    q   = num / mb;
    rm  = num % mb;
    lead   = q[64] ? 64 : 63;
    shift  = lead - mw;
    sig    = q >> shift;
    guard  = q[shift-1];
    sticky = ((q & ((128'd1 << (shift - 1)) - 128'd1)) != 0) || (rm != 0);
    e = ea - eb + bias - ((lead == 63) ? 1 : 0);
    if (guard && (sticky || sig[0])) sig = sig + 128'd1;
    if ((sig >> (mw + 1)) != 0) begin
      sig = sig >> 1;
      e   = e + 1;
    end
    if (e >= emax) return {4'b1000, inf_v};
    if (e <= 0) return {4'b0100, zero_v};
    r64 = zero_v | (64'(e) << mw) | (sig[63:0] & fmask);
    return {4'b0000, r64};
  endfunction

  function automatic logic [63:0] rand_op(input int ew, input int mw);
    int k, emax, ex;
    logic [63:0] fr, fmask;
    emax  = (1 << ew) - 1;
    fmask = (64'd1 << mw) - 64'd1;
    k  = $urandom_range(0, 15);
    fr = {$urandom, $urandom} & fmask;
    if (k == 0)      ex = 0;
    else if (k == 1) begin ex = emax; fr = 64'd0; end
    else if (k == 2) ex = emax;
    else if (k == 3) begin ex = $urandom_range(1, emax - 1); fr = fmask; end
    else             ex = $urandom_range(1, emax - 1);
    return (64'($urandom_range(0, 1)) << (ew + mw)) | (64'(ex) << mw) | fr;
  endfunction

  function automatic logic [67:0] pack32();
    return {overflow, underflow, invalid, div_by_zero, 32'h0, res};
  endfunction

  task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [67:0] expv, input bit push);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    if (push) exp_q.push_back(expv);
    @(posedge clk); #1;
    start = 1'b0;
    op_a  = $urandom;
    op_b  = $urandom;
  endtask

  // Waits for done, checking latency, busy and the scoreboard head; optional
  // extra start pulses (edge numbers p1/p2 after the start edge) with new operands.
  task automatic wait_done(input string name, input int lat, input int p1, input int p2);
    int   edges;
    bit   got, busy_ok;
    logic [67:0] expv;
    edges = 0; got = 0; busy_ok = 1;
    while (!got && edges < lat + 10) begin
      if (p1 != 0 && (edges + 1 == p1 || edges + 1 == p2)) begin
        op_a = ONE; op_b = THREE; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
      if (done) got = 1;
      else if (!busy) busy_ok = 0;
    end
    start = 1'b0;
    expv = (exp_q.size() > 0) ? exp_q.pop_front() : 68'h0;
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s timeout: no done after %0d edges, required %0d", name, edges, lat);
    end else begin
      check({name, " busy_held"}, 68'(busy_ok), 68'd1);
      check({name, " latency"}, 68'(edges), 68'(lat));
      check({name, " busy_at_done"}, 68'(busy), 68'd0);
      check({name, " result"}, pack32(), expv);
    end
  endtask

  task automatic run64(input string name, input logic [63:0] a, input logic [63:0] b,
                       input logic [67:0] expv);
    int edges;
    op_a64 = a; op_b64 = b; start64 = 1'b1;
    @(posedge clk); #1;
    start64 = 1'b0; op_a64 = '0; op_b64 = '0;
    edges = 0;
    while (!done64 && edges < 70) begin
      @(posedge clk); #1;
      edges++;
    end
    check({name, " latency"}, 68'(edges), 68'd56);
    check({name, " result"}, {ovf64, unf64, inv64, dz64, res64}, expv);
  endtask

  initial begin
    int cnt;
    logic [31:0] ra, rb;
    logic [63:0] ra64, rb64;

    vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, "6/2"};
    vecs[1]  = '{ONE,          THREE,        32'h3EAAAAAB, 4'b0000, "1/3_rne"};
    vecs[2]  = '{ONE,          ONE,          ONE,          4'b0000, "1/1"};
    vecs[3]  = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, "-6/2"};
    vecs[4]  = '{ONE,          32'h00000000, 32'h7F800000, 4'b0001, "1/0"};
    vecs[5]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 4'b0010, "0/0"};
    vecs[6]  = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b0010, "inf/inf"};
    vecs[7]  = '{32'h7FC00001, ONE,          32'h7FC00000, 4'b0010, "nan/1"};
    vecs[8]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b1000, "overflow"};
    vecs[9]  = '{32'h00800000, 32'h40000000, 32'h00000000, 4'b0100, "underflow"};
    vecs[10] = '{ONE,          32'h7F800000, 32'h00000000, 4'b0000, "1/inf"};

    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
    start64 = 1'b0; op_a64 = '0; op_b64 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", {busy, done, overflow, underflow, invalid, div_by_zero, 30'h0, res},
          68'h0);
    check("reset state", 68'(dbg_state), 68'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors issued back-to-back in the done cycle.
    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b, {vecs[i].flags, 32'h0, vecs[i].res}, 1'b1);
      wait_done(vecs[i].name, 27, 0, 0);
    end
    @(posedge clk); #1;
    check("done_single_cycle", 68'(done), 68'd0);
    check("flags_hold", pack32(), {4'b0000, 32'h0, 32'h00000000});

    // Starts during busy must be ignored.
    start_op(32'h40C00000, 32'h40000000, {4'b0000, 32'h0, 32'h40400000}, 1'b1);
    wait_done("ignored_start", 27, 5, 26);
    cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
    check("ignored_start extra_done", 68'(cnt), 68'd0);
    check("ignored_start res_hold", pack32(), {4'b0000, 32'h0, 32'h40400000});

    // Abort with reset mid-operation.
    start_op(ONE, THREE, 68'h0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort outputs", {busy, done, overflow, underflow, invalid, div_by_zero, 30'h0, res},
          68'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
    check("abort no_done", 68'(cnt), 68'd0);
    start_op(ONE, THREE, {4'b0000, 32'h0, 32'h3EAAAAAB}, 1'b1);
    wait_done("after_abort", 27, 0, 0);

    // Random operands against the reference model.
    for (int i = 0; i < 150; i++) begin
      ra = 32'(rand_op(8, 23));
      rb = 32'(rand_op(8, 23));
      start_op(ra, rb, model(8, 23, {32'h0, ra}, {32'h0, rb}), 1'b1);
      wait_done("random", 27, 0, 0);
    end

    // Double-width instance.
    run64("dp 1/3", 64'h3FF0000000000000, 64'h4008000000000000, {4'b0000, 64'h3FD5555555555555});
    for (int i = 0; i < 20; i++) begin
      ra64 = rand_op(11, 52);
      rb64 = rand_op(11, 52);
      run64("dp random", ra64, rb64, model(11, 52, ra64, rb64));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fp_div_serial.md
# fp_div_serial

Parametrised IEEE-754-style floating-point divider computing res = op_a / op_b with a radix-2 restoring mantissa divider, one quotient bit per cycle. It is the next generation of the single-precision divider in the FPU. It adds configurable exponent/fraction widths, round-to-nearest-even, full special-case handling, real status flags and a busy/done handshake. It sits behind the FPU issue logic as a multi-cycle unit; one operation is in flight at a time.

## Interface
- EXP_W, 8, exponent field width; BIAS = 2^(EXP_W-1)-1
- MAN_W, 23, stored fraction width; word width DATA_W = 1+EXP_W+MAN_W
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request; sampled only when busy=0
- op_a  in  DATA_W  dividend {sign, exp, frac}
- op_b  in  DATA_W  divisor
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse, res/flags valid
- res  out  DATA_W  quotient
- overflow  out  1  finite result rounded above max, res = ±inf
- underflow  out  1  nonzero result below min normal, flushed to ±0
- invalid  out  1  NaN operand, 0/0 or inf/inf
- div_by_zero  out  1  finite nonzero / zero

## Operation
- States: IDLE -> DIV -> ROUND -> IDLE.
- IDLE: start=1 latches operands, classifies them, loads the divider, sets busy and enters DIV.
- Classification: exp==0 means zero; subnormal inputs are treated as ±0. exp all-ones with frac==0 means inf; exp all-ones with frac!=0 means NaN.
- DIV runs for exactly MAN_W+3 cycles (counter 0..MAN_W+2). Q = ({1,fa} << (MAN_W+2)) / {1,fb}, MSB first. The remainder is kept for the sticky bit.
- Q lies in (0.5, 2), so its leading one is at bit MAN_W+2 (Ma>=Mb) or at bit MAN_W+1 (Ma<Mb).
- Normalise: if the leading one is at MAN_W+1, shift Q left by 1 and decrement the exponent. Then take MAN_W fraction bits, guard = next bit, sticky = remaining Q bits OR (remainder != 0).
- Round to nearest, ties to even: increment when guard & (sticky | lsb). A carry out of the significand sets the fraction to 0 and increments the exponent.
- Exponent arithmetic: e = Ea - Eb + BIAS (minus 1 if normalised), computed signed in EXP_W+2 bits.
- After rounding: e >= 2^EXP_W-1 gives ±inf with overflow=1. e <= 0 gives ±0 with underflow=1.
- Sign = sa ^ sb for all results except NaN.
- Special-case priority: the DIV sequence still runs and the cycle count is unchanged; the special result overrides at ROUND.
  1. Any NaN, 0/0 or inf/inf: canonical qNaN {0, all-ones, 1, 0...0}, invalid=1.
  2. finite/0: ±inf, div_by_zero=1.
  3. inf/finite: ±inf, no flag.
  4. 0/nonzero or finite/inf: ±0, no flag.
- ROUND registers res and the flags, pulses done, clears busy and returns to IDLE.
- res and the flags hold until the next done. All four flags are written on every done.

## Timing
- Reset (async): state IDLE, busy=0, done=0, res=0, all flags 0.
- Fixed latency for every operand class: start sampled at edge T gives done=1 for the cycle after edge T+MAN_W+4 (edge T+27 at defaults). busy=1 from after edge T until done rises.
- start while busy=1 is ignored; its operands are not captured.
- start in the cycle done=1 is accepted (busy=0 then), allowing back-to-back operations with period MAN_W+4.
- op_a/op_b may change after the start edge without affecting the result.
- rst mid-operation aborts: no done, outputs return to reset values, next start behaves normally.

## Test plan
- 0x40C00000 / 0x40000000 -> res 0x40400000, no flags, done exactly 27 edges after start; busy high edges 1..27.
- 0x3F800000 / 0x40400000 -> 0x3EAAAAAB (RNE rounds up); 0x3F800000 / 0x3F800000 -> 0x3F800000; -6.0 (0xC0C00000) / 2.0 -> 0xC0400000.
- 0x3F800000 / 0x00000000 -> 0x7F800000 with div_by_zero; 0/0 -> 0x7FC00000 with invalid; 0x7F800000/0x7F800000 -> 0x7FC00000 with invalid; 0x7FC00001 / 1.0 -> 0x7FC00000 with invalid.
- 0x7F000000 / 0x3E800000 -> 0x7F800000 with overflow; 0x00800000 / 0x40000000 -> 0x00000000 with underflow; 1.0 / 0x7F800000 -> 0x00000000, no flags.
- Pulse start again at edges 5 and 26 during 6.0/2.0 -> both ignored, single done, res 0x40400000. Start in the done cycle -> second result 27 edges later.
- Assert rst at edge 10 of an operation -> no done, res=0, flags=0. Then 1.0/3.0 completes normally; rerun at EXP_W=11, MAN_W=52: 1.0/3.0 -> 0x3FD5555555555555 after 56 edges.
